// File: rtl/video_timing_gen.sv
// Raw video timing source: pixel clock enable, sync/blank pulses and pixel coordinates,
// all registered on CLK_VIDEO so they feed the mixer without skew.
module video_timing_gen #(
  parameter int unsigned CE_DIV   = 4,
  parameter int unsigned H_ACTIVE = 320,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 32,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 240,
  parameter int unsigned V_FP     = 4,
  parameter int unsigned V_SYNC   = 3,
  parameter int unsigned V_BP     = 65
) (
  input  logic       CLK_VIDEO,
  input  logic       reset,
  output logic       ce_pix,
  output logic       HSync,
  output logic       VSync,
  output logic       HBlank,
  output logic       VBlank,
  output logic [9:0] hcount,
  output logic [9:0] vcount,
  output logic       line_start,
  output logic       frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [3:0] DIV_LAST     = 4'(CE_DIV - 1);
  localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
  localparam logic [9:0] HBLANK_START = 10'(H_ACTIVE);
  localparam logic [9:0] HSYNC_START  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HSYNC_END    = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VBLANK_START = 10'(V_ACTIVE);
  localparam logic [9:0] VSYNC_START  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VSYNC_END    = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [3:0] divCount_q, divCount_d;
  logic       cePix_q, cePix_d;
  logic [9:0] hCount_q, hCount_d;
  logic [9:0] vCount_q, vCount_d;
  logic       hSync_q, hSync_d;
  logic       vSync_q, vSync_d;
  logic       hBlank_q, hBlank_d;
  logic       vBlank_q, vBlank_d;
  logic       lineStart_q, lineStart_d;
  logic       frameStart_q, frameStart_d;

  // Decodes are taken from the next counter values so every flag lines up with its pixel.
  always_comb begin
    divCount_d = (divCount_q == DIV_LAST) ? 4'd0 : divCount_q + 4'd1;
    cePix_d    = (divCount_q == DIV_LAST);
    hCount_d   = hCount_q;
    vCount_d   = vCount_q;
    if (cePix_q) begin
      if (hCount_q == H_LAST) begin
        hCount_d = 10'd0;
        vCount_d = (vCount_q == V_LAST) ? 10'd0 : vCount_q + 10'd1;
      end else begin
        hCount_d = hCount_q + 10'd1;
      end
    end
    hBlank_d     = (hCount_d >= HBLANK_START);
    hSync_d      = (hCount_d >= HSYNC_START) && (hCount_d < HSYNC_END);
    vBlank_d     = (vCount_d >= VBLANK_START);
    vSync_d      = (vCount_d >= VSYNC_START) && (vCount_d < VSYNC_END);
    lineStart_d  = cePix_d && (hCount_d == 10'd0);
    frameStart_d = lineStart_d && (vCount_d == 10'd0);
  end

  always_ff @(posedge CLK_VIDEO) begin
    if (reset) begin
      divCount_q   <= 4'd0;
      cePix_q      <= 1'b0;
      hCount_q     <= 10'd0;
      vCount_q     <= 10'd0;
      hSync_q      <= 1'b0;
      vSync_q      <= 1'b0;
      hBlank_q     <= 1'b0;
      vBlank_q     <= 1'b0;
      lineStart_q  <= 1'b0;
      frameStart_q <= 1'b0;
    end else begin
      divCount_q   <= divCount_d;
      cePix_q      <= cePix_d;
      hCount_q     <= hCount_d;
      vCount_q     <= vCount_d;
      hSync_q      <= hSync_d;
      vSync_q      <= vSync_d;
      hBlank_q     <= hBlank_d;
      vBlank_q     <= vBlank_d;
      lineStart_q  <= lineStart_d;
      frameStart_q <= frameStart_d;
    end
  end

  assign ce_pix      = cePix_q;
  assign HSync       = hSync_q;
  assign VSync       = vSync_q;
  assign HBlank      = hBlank_q;
  assign VBlank      = vBlank_q;
  assign hcount      = hCount_q;
  assign vcount      = vCount_q;
  assign line_start  = lineStart_q;
  assign frame_start = frameStart_q;

endmodule
